ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
- Controller sitting between the PS2 receiver and the PicoBlaze port interface.
- Gates the receiver via rx_en and parses raw scan bytes (E0 extended prefix, F0 break prefix) into complete key events.
- Queues events in a first-word-fall-through FIFO and hands them to the processor with a valid/ack handshake.
- Replaces single-key, single-byte polling with buffered make/break/extended events.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- TIMEOUT_CYC, 1000000, clk cycles allowed between a prefix byte and its following byte before the partial sequence is discarded (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_done_tick  input  1  one-cycle pulse from the PS2 receiver: rx_data is valid.
- rx_data  input  8  scan byte from the PS2 receiver.
- rx_en  output  1  enable to the PS2 receiver; 1 = accept frames.
- evt_valid  output  1  FIFO non-empty; head event presented.
- evt_code  output  8  head event scan code.
- evt_ext  output  1  head event was E0-prefixed.
- evt_brk  output  1  head event is a release (F0-prefixed).
- evt_ack  input  1  one-cycle pop strobe from the processor port write; ignored when evt_valid = 0.
- ovf  output  1  sticky flag: an event was dropped.
- ovf_clr  input  1  clears ovf.
- fifo_count  output  $clog2(DEPTH)+1  number of queued events.

Behaviour:
- Reset (async): parser in IDLE, FIFO empty, timeout counter 0. Output values during reset: evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, ovf=0, fifo_count=0, rx_en=1.
- Parser FSM, advances only on rx_done_tick:
  - IDLE: E0 -> EXT; F0 -> BRK; 00 or FF (keyboard error codes) -> ignored, stay IDLE; any other byte -> push {ext=0, brk=0, code}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT and restart the timeout; 00/FF -> IDLE, no push; other -> push {1, 0, code}, then IDLE.
  - BRK: E0 or F0 -> IDLE, no push (malformed); 00/FF -> IDLE; other -> push {0, 1, code}, then IDLE.
  - EXT_BRK: E0/F0/00/FF -> IDLE, no push; other -> push {1, 1, code}, then IDLE.
- Timeout:
  - Counter runs only in EXT, BRK and EXT_BRK, and clears on every rx_done_tick and on entry to IDLE.
  - When it reaches TIMEOUT_CYC-1 with no byte received, the FSM returns to IDLE next cycle with no push.
- FIFO:
  - First-word-fall-through: evt_* reflect the head entry combinationally from registered storage.
  - Pointers wrap modulo DEPTH.
  - Push occurs in the cycle after the rx_done_tick that completes an event.
  - Pop on evt_ack && evt_valid.
  - Pop alone decrements fifo_count.
  - Push and pop in the same cycle: both take effect, count unchanged. This includes when the FIFO is full.
  - Push while full without a same-cycle pop: entry dropped, ovf set next cycle, count stays DEPTH.
  - ovf_clr clears ovf. If ovf_clr and an overflow occur in the same cycle, the set wins.
  - When empty, evt_code/ext/brk hold the last popped value. Only evt_valid is meaningful.
- Flow control:
  - rx_en = 0 when fifo_count >= DEPTH-1, otherwise 1. The FIFO keeps one slot of headroom for a frame already in flight.
  - rx_en is registered: it changes the cycle after fifo_count changes.
  - Bytes arriving while rx_en = 0 are still parsed normally.
- Latency: rx_done_tick of the final byte -> evt_valid high 2 cycles later when the FIFO was empty.

Test Plan:
- 1C -> one event: code=1C, ext=0, brk=0, fifo_count=1; evt_ack pulse -> evt_valid=0, count=0.
- E0 F0 75 -> one event: code=75, ext=1, brk=1. F0 1C -> one event: code=1C, ext=0, brk=1. No intermediate pushes.
- E0, then no byte for TIMEOUT_CYC cycles (TIMEOUT_CYC overridden to 100 in the bench), then 1C -> single event code=1C, ext=0. Also: F0 E0 1C -> only event code=1C, ext=0, brk=0.
- DEPTH=8, push 7 codes with no ack -> rx_en=0 after the 7th. Push 8th and 9th -> count=8, ovf=1, head still code #1. Pop all 8 -> codes in order, rx_en returns to 1 once count < 7. ovf_clr -> ovf=0.
- FIFO full, then evt_ack in the same cycle as a completing push -> count stays 8, ovf stays 0, new code lands at the tail.
- Async reset asserted mid-sequence (after E0) with 3 events queued -> all outputs return to reset values immediately. After release, byte 1C yields an event with ext=0.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// Purpose: parses PS2 scan bytes (E0 extended / F0 break prefixes) into key events,
//          queues them in a first-word-fall-through FIFO and hands them to the CPU
//          through a valid/ack handshake.
// Latency: final byte rx_done_tick -> evt_valid two cycles later (FIFO empty).
// Backpressure: rx_en (registered) drops once DEPTH-1 events are queued; a push into
//          a full FIFO with no same-cycle pop is dropped and sets sticky ovf.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   rx_done_tick      receiver strobe, rx_data valid
//   rx_data[7:0]      scan byte
//   rx_en             receiver enable (1 = accept frames)
//   evt_valid         head event present
//   evt_code/ext/brk  head event fields
//   evt_ack           pop strobe (ignored while empty)
//   ovf, ovf_clr      sticky drop flag and its clear
//   fifo_count        number of queued events
module ps2_key_event_ctrl #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_done_tick,
    input  logic [7:0]               rx_data,
    output logic                     rx_en,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    output logic                     evt_ext,
    output logic                     evt_brk,
    input  logic                     evt_ack,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HI   = CW'(DEPTH - 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   to_cnt_q;
    logic            is_e0, is_f0, is_err;
    logic            push_now;
    evt_t            push_new;
    logic            push_vld_q;
    evt_t            push_dat_q;

    evt_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    evt_t            last_q;
    evt_t            head;
    logic            full, do_push, do_pop, ovf_set;
    logic            ovf_q, rx_en_q;

    assign is_e0  = (rx_data == 8'hE0);
    assign is_f0  = (rx_data == 8'hF0);
    assign is_err = (rx_data == 8'h00) || (rx_data == 8'hFF);

    // ---------------- parser FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- parser FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (rx_done_tick) begin
            case (state_q)
                S_IDLE:  state_d = is_e0 ? S_EXT : (is_f0 ? S_BRK : S_IDLE);
                S_EXT:   state_d = is_f0 ? S_EXT_BRK : (is_e0 ? S_EXT : S_IDLE);
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TO_MAX) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- parser FSM: outputs ----------------
    // Any non-prefix, non-error byte completes an event; the current state
    // alone tells which prefixes preceded it. Prefixes in illegal positions
    // fall through to IDLE in the next-state logic without pushing.
    always_comb begin
        push_now      = rx_done_tick && !is_e0 && !is_f0 && !is_err;
        push_new.ext  = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        push_new.brk  = (state_q == S_BRK) || (state_q == S_EXT_BRK);
        push_new.code = rx_data;
    end

    // Inter-byte timeout; cleared by every byte and whenever the parser idles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                to_cnt_q <= '0;
        else if (rx_done_tick || state_d == S_IDLE) to_cnt_q <= '0;
        else                                      to_cnt_q <= to_cnt_q + 1'b1;
    end

    // Completed event is staged one cycle before entering the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
        end else begin
            push_vld_q <= push_now;
            if (push_now) push_dat_q <= push_new;
        end
    end

    // ---------------- event FIFO ----------------
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = evt_ack && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_vld_q && (!full || do_pop);
    assign ovf_set = push_vld_q && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_dat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            rx_en_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            // Lags count by one cycle; one slot of headroom covers a frame in flight.
            rx_en_q <= (count_q < CNT_HI);
        end
    end

    // When empty, hold the last popped event rather than stale storage.
    assign head       = (count_q == '0) ? last_q : mem[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_brk    = head.brk;
    assign ovf        = ovf_q;
    assign rx_en      = rx_en_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_ack = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic [3:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];   // {ext, brk, code}

    ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data), .rx_en(rx_en),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
        .evt_ack(evt_ack), .ovf(ovf), .ovf_clr(ovf_clr), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_evt(input logic ext, input logic brk, input logic [7:0] code,
                            input logic keep);
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
        if (keep) exp_q.push_back({ext, brk, code});
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        int         n;
        n = 0;
        while (!evt_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!evt_valid) begin
            chk({tag, "_timeout"}, 32'(evt_valid), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(evt_valid), 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk(tag, {22'd0, evt_ext, evt_brk, evt_code}, {22'd0, e});
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_cnt"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({tag, "_rxen"}, 32'(rx_en), 32'(exp_q.size() < DEPTH - 1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_code",  32'(evt_code), 0);
        chk("rst_flags", {30'd0, evt_ext, evt_brk}, 0);
        chk("rst_ovf",   32'(ovf), 0);
        chk("rst_cnt",   32'(fifo_count), 0);
        chk("rst_rxen",  32'(rx_en), 1);

        // Plain make code, with latency check: valid exactly two cycles after tick
        @(negedge clk);
        rx_data = 8'h1C; rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        chk("lat_1", 32'(evt_valid), 0);
        @(negedge clk);
        chk("lat_2", 32'(evt_valid), 1);
        chk("cnt_1", 32'(fifo_count), 1);
        exp_q.push_back({2'b00, 8'h1C});
        pop_check("make_1c");
        chk("empty_valid", 32'(evt_valid), 0);
        chk("empty_hold",  32'(evt_code), 32'h1C);

        // Extended break and plain break; prefixes alone push nothing
        send_byte(8'hE0);
        send_byte(8'hF0);
        chk("no_partial", 32'(fifo_count), 0);
        send_byte(8'h75);
        exp_q.push_back({2'b11, 8'h75});
        pop_check("ext_brk_75");
        send_evt(1'b0, 1'b1, 8'h1C, 1'b1);
        pop_check("brk_1c");

        // Error codes ignored; repeated E0 keeps extended state
        send_byte(8'hFF);
        send_byte(8'h00);
        chk("err_ignored", 32'(fifo_count), 0);
        send_byte(8'hE0);
        send_evt(1'b1, 1'b0, 8'h75, 1'b1);
        pop_check("e0e0_75");

        // Just inside the timeout window the prefix still applies
        send_byte(8'hE0);
        repeat (90) @(negedge clk);
        send_byte(8'h6B);
        exp_q.push_back({2'b10, 8'h6B});
        pop_check("pre_timeout");

        // Timeout discards the pending E0
        send_byte(8'hE0);
        repeat (110) @(negedge clk);
        chk("to_nopush", 32'(fifo_count), 0);
        send_evt(1'b0, 1'b0, 8'h1C, 1'b1);
        pop_check("post_timeout");

        // Malformed F0 E0 returns to idle
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_evt(1'b0, 1'b0, 8'h1C, 1'b1);
        pop_check("f0e0_1c");

        // Fill, flow control, overflow
        for (int i = 0; i < 7; i++) begin
            send_evt(1'b0, 1'b0, 8'(8'h10 + i), 1'b1);
            if (i == 5) chk("rxen_at6", 32'(rx_en), 1);
        end
        chk("rxen_at7", 32'(rx_en), 0);
        chk("cnt_7", 32'(fifo_count), 7);
        send_evt(1'b0, 1'b0, 8'h17, 1'b1);
        chk("ovf_before", 32'(ovf), 0);
        send_evt(1'b0, 1'b0, 8'h18, 1'b0);
        chk("cnt_full", 32'(fifo_count), 8);
        chk("ovf_set", 32'(ovf), 1);
        chk("head_first", 32'(evt_code), 32'h10);
        for (int i = 0; i < 8; i++) pop_check("drain");
        chk("ovf_sticky", 32'(ovf), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);

        // Full FIFO: ack coincides with the completing push
        for (int i = 0; i < 8; i++) send_evt(1'b0, 1'b0, 8'(8'h20 + i), 1'b1);
        chk("full2", 32'(fifo_count), 8);
        @(negedge clk);
        rx_data = 8'h28; rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        evt_ack = 1'b1;
        begin
            logic [9:0] e;
            e = exp_q.pop_front();
            chk("simul_head", {22'd0, evt_ext, evt_brk, evt_code}, {22'd0, e});
        end
        exp_q.push_back({2'b00, 8'h28});
        @(negedge clk);
        evt_ack = 1'b0;
        @(negedge clk);
        chk("simul_cnt", 32'(fifo_count), 8);
        chk("simul_ovf", 32'(ovf), 0);
        for (int i = 0; i < 8; i++) pop_check("drain2");

        // Async reset mid-sequence with queued events
        for (int i = 0; i < 3; i++) send_evt(1'b0, 1'b1, 8'(8'h30 + i), 1'b1);
        send_byte(8'hE0);
        chk("pre_rst_cnt", 32'(fifo_count), 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_cnt",   32'(fifo_count), 0);
        chk("arst_fields", {22'd0, evt_ext, evt_brk, evt_code}, 0);
        chk("arst_ovf",   32'(ovf), 0);
        chk("arst_rxen",  32'(rx_en), 1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        send_evt(1'b0, 1'b0, 8'h1C, 1'b1);
        pop_check("post_rst");
        chk("final_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
